// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide sequencer owning HI/LO
// Optional abort/flush input enabled by defining MDU_ABORT_EN.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_ABORT_EN
    input  logic        abort,
`endif
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_rd_sel,
    input  logic        md_instr_d,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     pend_hi, pend_lo;
    logic            pend_wr;
    logic            pend_load;
    logic            abort_w;

`ifdef MDU_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    logic op_is_mult, op_is_div;
    assign op_is_mult = (md_op == 3'd1) || (md_op == 3'd2);
    assign op_is_div  = (md_op == 3'd3) || (md_op == 3'd4);

    assign busy     = (state_q == RUN);
    assign start    = (state_q == IDLE) && (op_is_mult || op_is_div);
    assign stall_md = md_instr_d & (start | busy);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_out   = md_rd_sel ? hi_q : lo_q;

    // Sign-extending to 64 bits lets one unsigned multiplier give the signed product.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Signed divide works on magnitudes; a zero divisor is swapped for 1 to keep the datapath defined.
    logic        div_by_zero;
    logic [31:0] mag_a, mag_b, mag_b_nz, b_nz;
    logic [31:0] uq_s, ur_s, q_s, r_s, uq_u, ur_u;
    assign div_by_zero = (src_b == 32'd0);
    assign mag_a       = src_a[31] ? (32'd0 - src_a) : src_a;
    assign mag_b       = src_b[31] ? (32'd0 - src_b) : src_b;
    assign mag_b_nz    = div_by_zero ? 32'd1 : mag_b;
    assign b_nz        = div_by_zero ? 32'd1 : src_b;
    assign uq_s        = mag_a / mag_b_nz;
    assign ur_s        = mag_a % mag_b_nz;
    assign q_s         = (src_a[31] ^ src_b[31]) ? (32'd0 - uq_s) : uq_s;
    assign r_s         = src_a[31] ? (32'd0 - ur_s) : ur_s;
    assign uq_u        = src_a / b_nz;
    assign ur_u        = src_a % b_nz;

    logic [31:0] res_hi, res_lo;
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md_op)
            3'd1:    begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            3'd2:    begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            3'd3:    begin res_hi = r_s;           res_lo = q_s;          end
            3'd4:    begin res_hi = ur_u;          res_lo = uq_u;         end
            default: begin res_hi = 32'd0;         res_lo = 32'd0;        end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (!abort_w) begin
                    if (start) begin
                        state_d   = RUN;
                        cnt_d     = op_is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        pend_load = 1'b1;
                    end else if (md_op == 3'd5) begin
                        hi_d = src_a;
                    end else if (md_op == 3'd6) begin
                        lo_d = src_a;
                    end
                end
            end
            RUN: begin
                if (abort_w) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (pend_wr) begin
                        hi_d = pend_hi;
                        lo_d = pend_lo;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (pend_load) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= !(op_is_div && div_by_zero);
            end else if (state_d == IDLE) begin
                pend_hi <= 32'd0;
                pend_lo <= 32'd0;
                pend_wr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        md_rd_sel = 1'b0;
    logic        md_instr_d = 1'b0;
    logic        start, busy, stall_md;
    logic [31:0] md_out, hi, lo;

    int assertions = 0;
    int failures   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef MDU_ABORT_EN
        .abort      (abort),
`endif
        .md_op      (md_op),
        .src_a      (src_a),
        .src_b      (src_b),
        .md_rd_sel  (md_rd_sel),
        .md_instr_d (md_instr_d),
        .start      (start),
        .busy       (busy),
        .stall_md   (stall_md),
        .md_out     (md_out),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          n;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Architectural result from plain 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] ch, input logic [31:0] cl);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin p = sa * sb; return p; end
            3'd2: begin p = ua * ub; return p; end
            3'd3: begin
                if (b == 32'd0) return {ch, cl};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {ch, cl};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            3'd5: return {a, cl};
            3'd6: return {ch, a};
            default: return {ch, cl};
        endcase
    endfunction

    function automatic int op_cycles(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 5;
        if (op == 3'd3 || op == 3'd4) return 10;
        return 0;
    endfunction

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int n);
        int cycles;
        @(negedge clk);
        md_op = op;
        src_a = a;
        src_b = b;
        #1;
        chk({name, "_start"}, {31'd0, start}, {31'd0, (op >= 3'd1 && op <= 3'd4)});
        @(negedge clk);
        md_op = 3'd0;
        cycles = 0;
        while (busy && cycles < 60) begin
            cycles++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, cycles, n);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{3'd5, 32'h00000011, 32'd0,        32'h00000011, 32'hFFFFFFFD, 0};
        vecs[4] = '{3'd6, 32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
        vecs[5] = '{3'd4, 32'd7,        32'd0,        32'h00000011, 32'h00000022, 10};
        vecs[6] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[7] = '{3'd7, 32'hDEADBEEF, 32'd5,        32'h00000000, 32'h80000000, 0};
        vecs[8] = '{3'd5, 32'h00001234, 32'd0,        32'h00001234, 32'h80000000, 0};
        vecs[9] = '{3'd6, 32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0};

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].n);

        md_rd_sel = 1'b1;
        #1 chk("md_out_hi", md_out, 32'h00001234);
        md_rd_sel = 1'b0;
        #1 chk("md_out_lo", md_out, 32'h00005678);

        // Stall window, plus a stray op while busy that must be ignored.
        @(negedge clk);
        md_instr_d = 1'b1;
        md_op = 3'd1;
        src_a = 32'd3;
        src_b = 32'd4;
        #1 chk("stall_start_cycle", {31'd0, stall_md}, 32'd1);
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("stall_busy%0d", k), {30'd0, busy, stall_md}, 32'd3);
            if (k == 2) begin
                md_op = 3'd1;
                src_a = 32'd100;
                src_b = 32'd100;
                #1 chk("start_while_busy", {31'd0, start}, 32'd0);
            end else begin
                md_op = 3'd0;
            end
            @(negedge clk);
        end
        md_op = 3'd0;
        chk("stall_commit", {30'd0, busy, stall_md}, 32'd0);
        chk("stall_hi", hi, 32'd0);
        chk("stall_lo", lo, 32'd12);
        md_instr_d = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd12;

        // Reset during a divide.
        @(negedge clk);
        md_op = 3'd3;
        src_a = 32'd100;
        src_b = 32'd7;
        @(negedge clk);
        md_op = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        do_op("post_reset_mult", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5);
        repeat (12) @(negedge clk);
        chk("no_stale_commit", lo, 32'd42);

`ifdef MDU_ABORT_EN
        do_op("abort_prep", 3'd5, 32'hAA, 32'd0, 32'hAA, 32'd42, 0);
        @(negedge clk);
        md_op = 3'd1;
        src_a = 32'd9;
        src_b = 32'd9;
        @(negedge clk);
        md_op = 3'd0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_hi", hi, 32'hAA);
        chk("abort_lo", lo, 32'd42);
        md_op = 3'd3;
        src_a = 32'd50;
        src_b = 32'd5;
        abort = 1'b1;
        @(negedge clk);
        md_op = 3'd0;
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("abort_start_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        md_op = 3'd5;
        src_a = 32'h77;
        abort = 1'b1;
        @(negedge clk);
        md_op = 3'd0;
        abort = 1'b0;
        chk("abort_mthi", hi, 32'hAA);
        m_hi = 32'hAA;
        m_lo = 32'd42;
`endif

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            logic [63:0] e;
            op = 3'($urandom_range(1, 6));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 16));
                default: ;
            endcase
            e = model(op, a, b, m_hi, m_lo);
            do_op($sformatf("rand%0d_op%0d", i, op), op, a, b, e[63:32], e[31:0], op_cycles(op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its sequencer, owning the HI/LO register pair.
- Sits beside the execute-stage ALU and takes the forwarded rs/rt operands from E.
- Models fixed MULT/DIV latencies with a busy counter.
- Raises a stall request to the hazard unit whenever the D-stage instruction touches HI/LO while the unit is starting or busy.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op  input  3  E-stage HI/LO operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- src_a  input  32  forwarded rs value from E.
- src_b  input  32  forwarded rt value from E.
- md_rd_sel  input  1  read select for mfhi/mflo: 0 selects LO, 1 selects HI.
- md_instr_d  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- start  output  1  combinational; 1 when md_op is 1..4 and busy=0.
- busy  output  1  registered; 1 while an operation is in flight.
- stall_md  output  1  combinational; md_instr_d & (start | busy).
- md_out  output  32  combinational; HI when md_rd_sel=1, else LO.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- States: IDLE (busy=0) and RUN (busy=1). Cycle counter cnt is sized to hold max(MULT_CYCLES, DIV_CYCLES).
- Reset: HI=0, LO=0, cnt=0, busy=0, pending result cleared. Reset overrides every other input on the same edge.
- IDLE, start=1 at edge t:
  - Latch the result into pending_hi/pending_lo and the op kind.
  - cnt <= MULT_CYCLES for ops 1–2, DIV_CYCLES for ops 3–4.
  - busy=1 during cycles t+1 .. t+N.
- RUN: cnt decrements each edge. On the edge where cnt==1: HI/LO <= pending values, busy <= 0. New values are visible in cycle t+N+1.
- Arithmetic:
  - mult: signed 64-bit product of src_a and src_b; HI = [63:32], LO = [31:0].
  - multu: unsigned 64-bit product, same split.
  - div: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero: full DIV_CYCLES busy period is still taken; HI and LO are left unchanged at commit.
- mthi/mtlo in IDLE: HI (or LO) <= src_a at that edge; no busy period.
- Any md_op 1..6 while busy=1 is ignored. The hazard unit guarantees this never occurs; the bench asserts it.
- mfhi/mflo need no handshake: stall_md holds the D-stage instruction until busy=0, so md_out is already committed when it is read.
- stall_md covers the start cycle so a back-to-back HI/LO instruction cannot enter E in the same cycle as the starting operation.
- Reset mid-RUN: operation discarded, HI = LO = 0, busy = 0 on the next cycle.

Optional Feature:
- Macro: MDU_ABORT_EN.
- Defined: adds input port abort (1 bit), used for exception/flush.
  - abort=1 in RUN at edge t: cnt <= 0, busy <= 0, pending result discarded, HI/LO keep their pre-operation values.
  - abort=1 coincident with start (IDLE): the operation is not launched.
  - abort=1 coincident with mthi/mtlo: the write is suppressed.
  - Reset has priority over abort.
- Undefined: no abort port; every started operation runs to commit.

Test Plan:
- mult, src_a=0xFFFFFFFE (-2), src_b=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div, src_a=0xFFFFFFF9 (-7), src_b=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 with prior HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO unchanged.
- mthi 0x1234 then mtlo 0x5678 on consecutive idle cycles -> hi=0x1234, lo=0x5678 one edge after each; md_rd_sel=1 gives md_out=0x1234.
- mult started while md_instr_d=1 -> stall_md=1 from the start cycle through the last busy cycle, 0 on the commit-visible cycle. md_op=1 presented while busy -> HI/LO and cnt unaffected.
- reset asserted at cycle 3 of a div -> next cycle busy=0, hi=lo=0; a new mult issued afterwards completes normally.
- MDU_ABORT_EN: abort on cycle 2 of a mult with prior HI=0xAA -> busy=0 next cycle, hi stays 0xAA. abort coincident with start -> busy never rises.
